fetch_issue_queue: RTL and testbench
====================================

Name: fetch_issue_queue

Overview:
Parametrised in-order instruction buffer between the I-cache fetch stage and the decode slots. It replaces the sentinel-based 4-entry staging of the previous generation with the following:
- an explicit-valid circular FIFO of DEPTH entries;
- per-lane fetch masks with lane compaction;
- ISSUE_W decode slots with per-slot ready and strict in-order prefix dispatch.
Redirects (branch mispredict, interrupt) flush the whole buffer in one cycle.

Parameters:
FETCH_W, 4, instructions per fetch packet (power of 2)
ISSUE_W, 2, decode slots, 1 <= ISSUE_W <= FETCH_W
DEPTH, 16, buffer entries (power of 2, >= 2*FETCH_W)
PC_W, 64, PC width
INST_W, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  redirect (decode j_bad / interrupt); empties the buffer
fetch_valid  in  1  fetch packet present
fetch_ready  out  1  buffer can absorb a full packet this cycle
fetch_mask  in  FETCH_W  per-lane valid; lane 0 is the lowest address
fetch_pc  in  FETCH_W*PC_W  lane i at bits [i*PC_W +: PC_W]
fetch_inst  in  FETCH_W*INST_W  lane i at bits [i*INST_W +: INST_W]
dec_valid  out  ISSUE_W  slot holds an instruction
dec_pc  out  ISSUE_W*PC_W  slot PCs, slot 0 = oldest
dec_inst  out  ISSUE_W*INST_W  slot instructions
dec_ready  in  ISSUE_W  decode slot can accept this cycle
count  out  $clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Storage: DEPTH-entry pc/inst arrays. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A registered count is kept; there is no sentinel PC.
- Reset (rst=1 at posedge): head=tail=0, count=0. In the cycle after reset, dec_valid=0, dec_pc/dec_inst=0 and fetch_ready=1. Array contents are not reset.
- Enqueue:
  - Occurs when fetch_valid && fetch_ready && !flush.
  - Set lanes of fetch_mask are compacted in ascending lane order and written to tail, tail+1, ... with wrap.
  - tail advances by popcount(fetch_mask). A mask of 0 with fetch_valid=1 is legal and advances nothing.
- fetch_ready = (DEPTH - count >= FETCH_W). It uses registered count only and gives no credit for same-cycle dequeue. It is a combinational output with no dependence on fetch_valid.
- Dequeue view (combinational from head/count, zero latency):
  - slot k shows entry head+k (with wrap).
  - dec_valid[k] = (count > k) && !flush.
  - When dec_valid[k]=0, dec_pc/dec_inst for slot k are forced to 0.
- In-order prefix dispatch: n_deq = the number of leading slots k with dec_valid[k] && dec_ready[k]. The first slot that is not ready blocks all younger slots even if they are ready. head advances by n_deq.
  - Example: ready=2'b10 with 2 valid gives n_deq=0. This intentionally drops the old "slot 2 fires alone" mode.
- Count update: count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue is supported. count never exceeds DEPTH, which is guaranteed by the fetch_ready rule.
- Flush:
  - Takes priority over enqueue and dequeue: head=tail=0, count=0 next cycle.
  - Any same-cycle fetch packet is dropped.
  - dec_valid is forced low during the flush cycle itself, so decode never consumes a stale instruction.
  - Flush while empty is a no-op.
- Priority order: rst > flush > (enq, deq concurrently).
- Wrap: an enqueue that straddles index DEPTH-1 -> 0 must store all lanes correctly. Dequeue slots that straddle the wrap read correctly.
- Full boundary: count = DEPTH-FETCH_W+1 gives fetch_ready=0, even if a dequeue happens the same cycle.
- Empty boundary: count=0 gives all dec_valid=0. An entry enqueued at cycle t is visible on dec_* at cycle t+1; there is no bypass.
- Assertions:
  - count <= DEPTH.
  - fetch_valid && !fetch_ready && !flush is legal: fetch holds the packet.

Decomposition:
- Shared package fiq_pkg holds:
  - default FETCH_W/ISSUE_W/DEPTH/PC_W/INST_W localparams;
  - PTR_W = $clog2(DEPTH);
  - a packed fetch_lane_t struct {pc, inst}.
- One sub-module, fetch_lane_compact: combinational; takes fetch_mask and produces per-lane prefix offsets and popcount n_enq.

Test Plan:
1. Reset with DEPTH=16, FETCH_W=4 -> count=0, fetch_ready=1, dec_valid=2'b00, dec_pc=0.
2. One packet, mask=4'b1111, PCs 0x8000_0000..0x8000_000C, dec_ready=2'b11 held -> cycle+1: slots show 0x...00/0x...04; cycle+2: 0x...08/0x...0C; cycle+3: dec_valid=0, count=0.
3. Mask=4'b1010 (lanes 1,3 with PCs 0x104, 0x10C) -> count=2, slot0=0x104, slot1=0x10C (compacted).
4. dec_ready=2'b10 with 2 valid -> no dequeue, count unchanged; then dec_ready=2'b01 -> only slot0 dequeued, old slot1 moves to slot0.
5. Fill to count=13 with dec_ready=0 -> fetch_ready=0 and a held packet is not written; dequeue 1 -> count=12, fetch_ready=1, packet accepted next cycle. Run 5 full cycles of the buffer to exercise pointer wrap, checking the PC sequence is contiguous.
6. count=6 with flush asserted together with fetch_valid -> dec_valid=0 in that cycle; next cycle count=0 and the dropped packet is absent. A new packet the following cycle appears at slot0 one cycle later.

Source files
------------

// File: rtl/fiq_pkg.sv
// Shared types and defaults for the fetch/issue instruction buffer.
package fiq_pkg;

    localparam int unsigned DEF_FETCH_W = 4;
    localparam int unsigned DEF_ISSUE_W = 2;
    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_PC_W    = 64;
    localparam int unsigned DEF_INST_W  = 32;

    localparam int unsigned PTR_W = $clog2(DEF_DEPTH);

    // One fetched instruction with its address, at the default widths.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_lane_t;

endpackage

// File: rtl/fetch_lane_compact.sv
// Lane compaction helper: for each fetch lane, the number of set mask bits
// below it (its write offset from tail), plus the total popcount.
module fetch_lane_compact
    import fiq_pkg::*;
#(
    parameter int unsigned FETCH_W = DEF_FETCH_W,
    parameter int unsigned CNT_W   = $clog2(FETCH_W) + 1
) (
    input  logic [FETCH_W-1:0]            fetch_mask,
    output logic [FETCH_W-1:0][CNT_W-1:0] lane_off,
    output logic [CNT_W-1:0]              n_enq
);

    // Running prefix sum of the mask, lane 0 first.
    always_comb begin
        logic [CNT_W-1:0] acc;
        lane_off = '0;
        acc      = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_off[i] = acc;
            acc         = acc + CNT_W'(fetch_mask[i]);
        end
        n_enq = acc;
    end

endmodule

// File: rtl/fetch_issue_queue.sv
// In-order instruction buffer between fetch and decode: circular FIFO with
// masked, compacted enqueue and strict in-order prefix dispatch.
module fetch_issue_queue
    import fiq_pkg::*;
#(
    parameter int unsigned FETCH_W = DEF_FETCH_W,
    parameter int unsigned ISSUE_W = DEF_ISSUE_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INST_W  = DEF_INST_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [FETCH_W-1:0]          fetch_mask,
    input  logic [FETCH_W*PC_W-1:0]     fetch_pc,
    input  logic [FETCH_W*INST_W-1:0]   fetch_inst,
    output logic [ISSUE_W-1:0]          dec_valid,
    output logic [ISSUE_W*PC_W-1:0]     dec_pc,
    output logic [ISSUE_W*INST_W-1:0]   dec_inst,
    input  logic [ISSUE_W-1:0]          dec_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned LANE_CNT_W = $clog2(FETCH_W) + 1;
    localparam int unsigned DEQ_W      = $clog2(ISSUE_W) + 1;

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [FETCH_W-1:0][LANE_CNT_W-1:0] lane_off;
    logic [LANE_CNT_W-1:0]              n_enq;
    logic [IDX_W-1:0]                   wr_idx [FETCH_W];
    logic [DEQ_W-1:0]                   n_deq;
    logic                               enq;

    fetch_lane_compact #(
        .FETCH_W (FETCH_W),
        .CNT_W   (LANE_CNT_W)
    ) u_compact (
        .fetch_mask (fetch_mask),
        .lane_off   (lane_off),
        .n_enq      (n_enq)
    );

    // Registered count only: a same-cycle dequeue gives no extra credit.
    assign fetch_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign enq         = fetch_valid && fetch_ready && !flush;
    assign count       = count_q;

    // Destination slot for each lane; pointer width makes the wrap implicit.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            wr_idx[i] = tail_q + IDX_W'(lane_off[i]);
        end
    end

    // Payload storage, intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (enq && fetch_mask[i]) begin
                pc_mem[wr_idx[i]]   <= fetch_pc[i*PC_W +: PC_W];
                inst_mem[wr_idx[i]] <= fetch_inst[i*INST_W +: INST_W];
            end
        end
    end

    // Decode view and in-order prefix dispatch count.
    always_comb begin
        logic [IDX_W-1:0] rd_idx;
        logic             blocked;
        dec_valid = '0;
        dec_pc    = '0;
        dec_inst  = '0;
        n_deq     = '0;
        blocked   = 1'b0;
        rd_idx    = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_idx = head_q + IDX_W'(k);
            if ((count_q > CNT_W'(k)) && !flush) begin
                dec_valid[k]                 = 1'b1;
                dec_pc[k*PC_W +: PC_W]       = pc_mem[rd_idx];
                dec_inst[k*INST_W +: INST_W] = inst_mem[rd_idx];
            end
            // First slot that cannot go stops every younger slot.
            if (!blocked && dec_valid[k] && dec_ready[k]) begin
                n_deq = n_deq + DEQ_W'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Pointer/count next state; flush overrides enqueue and dequeue.
    always_comb begin
        head_d  = head_q + IDX_W'(n_deq);
        tail_d  = enq ? (tail_q + IDX_W'(n_enq)) : tail_q;
        count_d = count_q + (enq ? CNT_W'(n_enq) : '0) - CNT_W'(n_deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    count_bound_a : assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue at FETCH_W=4, ISSUE_W=2, DEPTH=16.
module tb_fetch_issue_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [3:0]   fetch_mask;
    logic [255:0] fetch_pc;
    logic [127:0] fetch_inst;
    logic [1:0]   dec_valid;
    logic [127:0] dec_pc;
    logic [63:0]  dec_inst;
    logic [1:0]   dec_ready;
    logic [4:0]   count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_issue_queue #(
        .FETCH_W (4),
        .ISSUE_W (2),
        .DEPTH   (16),
        .PC_W    (64),
        .INST_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_mask  (fetch_mask),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_inst    (dec_inst),
        .dec_ready   (dec_ready),
        .count       (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hc0de_0000;
    endfunction

    task automatic drive_pkt(input logic [3:0] mask, input logic [63:0] base);
        fetch_valid = 1'b1;
        fetch_mask  = mask;
        for (int i = 0; i < 4; i++) begin
            fetch_pc[i*64 +: 64]   = base + 64'(4 * i);
            fetch_inst[i*32 +: 32] = inst_of(base + 64'(4 * i));
        end
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_mask  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] pc_next;
    logic [63:0] exp_head;
    int          mcount;
    int          ndeq;
    logic        fv;

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        fetch_pc   = '0;
        fetch_inst = '0;
        dec_ready  = 2'b00;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset state
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(fetch_ready), 64'd1);
        check("rst_valid", 64'(dec_valid), 64'd0);
        check("rst_pc", dec_pc[63:0], 64'd0);

        // 2. Full packet drained two per cycle
        dec_ready = 2'b11;
        drive_pkt(4'b1111, 64'h8000_0000);
        tick();
        idle();
        #1;
        check("p1_valid", 64'(dec_valid), 64'd3);
        check("p1_pc0", dec_pc[63:0], 64'h8000_0000);
        check("p1_pc1", dec_pc[127:64], 64'h8000_0004);
        check("p1_inst0", 64'(dec_inst[31:0]), 64'(inst_of(64'h8000_0000)));
        tick();
        check("p2_pc0", dec_pc[63:0], 64'h8000_0008);
        check("p2_pc1", dec_pc[127:64], 64'h8000_000c);
        check("p2_count", 64'(count), 64'd2);
        tick();
        check("p3_valid", 64'(dec_valid), 64'd0);
        check("p3_count", 64'(count), 64'd0);

        // 3. Sparse mask compacts into adjacent entries
        dec_ready = 2'b00;
        drive_pkt(4'b1010, 64'h100);
        tick();
        idle();
        #1;
        check("cmp_count", 64'(count), 64'd2);
        check("cmp_pc0", dec_pc[63:0], 64'h104);
        check("cmp_pc1", dec_pc[127:64], 64'h10c);
        check("cmp_inst1", 64'(dec_inst[63:32]), 64'(inst_of(64'h10c)));

        // 4. Younger-only ready dispatches nothing; oldest-only dispatches one
        dec_ready = 2'b10;
        tick();
        check("ord_count", 64'(count), 64'd2);
        check("ord_pc0", dec_pc[63:0], 64'h104);
        dec_ready = 2'b01;
        tick();
        check("ord1_count", 64'(count), 64'd1);
        check("ord1_valid", 64'(dec_valid), 64'd1);
        check("ord1_pc0", dec_pc[63:0], 64'h10c);
        dec_ready = 2'b11;
        tick();
        check("ord_drain", 64'(count), 64'd0);

        // 5. Full boundary, then sustained traffic across pointer wrap
        dec_ready = 2'b00;
        pc_next   = 64'h1000;
        for (int p = 0; p < 3; p++) begin
            drive_pkt(4'b1111, pc_next);
            pc_next += 64'd16;
            tick();
        end
        drive_pkt(4'b0001, pc_next);
        pc_next += 64'd4;
        tick();
        idle();
        #1;
        check("full_count13", 64'(count), 64'd13);
        drive_pkt(4'b1111, pc_next);
        #1;
        check("full_ready0", 64'(fetch_ready), 64'd0);
        tick();
        check("full_held", 64'(count), 64'd13);
        dec_ready = 2'b01;
        #1;
        check("full_no_credit", 64'(fetch_ready), 64'd0);
        tick();
        dec_ready = 2'b00;
        #1;
        check("full_count12", 64'(count), 64'd12);
        check("full_ready1", 64'(fetch_ready), 64'd1);
        check("full_head", dec_pc[63:0], 64'h1004);
        tick();
        idle();
        pc_next += 64'd16;
        #1;
        check("full_count16", 64'(count), 64'd16);
        check("full_ready_at16", 64'(fetch_ready), 64'd0);

        mcount   = 16;
        exp_head = 64'h1004;
        dec_ready = 2'b11;
        for (int c = 0; c < 60; c++) begin
            fv = (mcount <= 12) && (c < 36);
            if (fv) drive_pkt(4'b1111, pc_next);
            else idle();
            #1;
            check("wrap_count", 64'(count), 64'(mcount));
            check("wrap_ready", 64'(fetch_ready), 64'(mcount <= 12));
            if (mcount > 0) check("wrap_pc0", dec_pc[63:0], exp_head);
            if (mcount > 1) check("wrap_pc1", dec_pc[127:64], exp_head + 64'd4);
            ndeq = (mcount >= 2) ? 2 : mcount;
            exp_head += 64'(4 * ndeq);
            mcount -= ndeq;
            if (fv) begin
                pc_next += 64'd16;
                mcount  += 4;
            end
            tick();
        end
        idle();
        #1;
        check("wrap_empty", 64'(count), 64'd0);

        // 6. Flush with a concurrent packet
        dec_ready = 2'b00;
        drive_pkt(4'b1111, 64'h2000);
        tick();
        drive_pkt(4'b0011, 64'h2010);
        tick();
        idle();
        #1;
        check("fl_count6", 64'(count), 64'd6);
        flush = 1'b1;
        drive_pkt(4'b1111, 64'h9000);
        #1;
        check("fl_valid_low", 64'(dec_valid), 64'd0);
        check("fl_pc_zero", dec_pc[63:0], 64'd0);
        tick();
        flush = 1'b0;
        idle();
        #1;
        check("fl_count0", 64'(count), 64'd0);
        check("fl_after_valid", 64'(dec_valid), 64'd0);
        drive_pkt(4'b0001, 64'ha000);
        #1;
        check("fl_no_bypass", 64'(dec_valid), 64'd0);
        tick();
        idle();
        #1;
        check("fl_new_valid", 64'(dec_valid), 64'd1);
        check("fl_new_pc", dec_pc[63:0], 64'ha000);
        check("fl_new_count", 64'(count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
